// File: rtl/load_store_unit_if.sv
// Bundle between the load/store unit, the EX stage, the data bus and writeback.
// slave = the unit itself; master = the environment that drives it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        fault;
  logic [31:0] fault_addr;

  modport slave (
    input  req_valid, opcode, func3, addr, wdata, rd, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_rd, wb_data, stall, fault, fault_addr
  );

  modport master (
    output req_valid, opcode, func3, addr, wdata, rd, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_rd, wb_data, stall, fault, fault_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: single-beat req/ack bus access with byte lanes and load extension.
// MISALIGN_TRAP_EN: when defined, misaligned half/word accesses fault instead of aligning down.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        r_state, w_next;
  logic          r_load, r_fault;
  logic [2:0]    r_func3;
  logic [31:0]   r_addr, r_wdata, r_wb_data;
  logic [3:0]    r_be;
  logic [4:0]    r_rd;
  logic [TW-1:0] r_tmo;

  logic        w_is_load, w_is_store, w_accept, w_legal, w_misalign, w_bad, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ext;

  assign w_is_load  = (bus.opcode == OP_LOAD);
  assign w_is_store = (bus.opcode == OP_STORE);
  assign w_accept   = (r_state == IDLE) && bus.req_valid && (w_is_load || w_is_store);

  always_comb begin
    w_legal = 1'b0;
    case (bus.func3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = w_is_load;
      default:                w_legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((bus.func3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.func3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad = !w_legal || w_misalign;

  // Lane selection ignores the sub-size address bits, so untrapped misaligned
  // accesses fall back to the naturally aligned container.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wdata;
    case (bus.func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.wdata;
      end
    endcase
  end

  always_comb begin
    w_shift = bus.mem_rdata;
    case (r_func3[1:0])
      2'b00:   w_shift = bus.mem_rdata >> {r_addr[1:0], 3'b000};
      2'b01:   w_shift = bus.mem_rdata >> {r_addr[1], 4'b0000};
      default: w_shift = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_ext = w_shift;
    case (r_func3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ext = {24'h0, w_shift[7:0]};
      3'b101:  w_ext = {16'h0, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // Ack in the last allowed cycle takes priority over the timeout.
  assign w_tmo = (r_state == BUS) && !bus.mem_ack && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_bad) w_next = BUS;
      BUS:     if (bus.mem_ack) w_next = DONE;
               else if (w_tmo)  w_next = IDLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_load    <= 1'b0;
      r_fault   <= 1'b0;
      r_func3   <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_wb_data <= 32'h0;
      r_be      <= 4'b0000;
      r_rd      <= 5'd0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_next;
      r_fault <= w_accept && w_bad;
      if (w_accept) begin
        r_load  <= w_is_load;
        r_func3 <= bus.func3;
        r_addr  <= bus.addr;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_rd    <= bus.rd;
        r_tmo   <= '0;
      end
      if (r_state == BUS) begin
        if (bus.mem_ack) r_wb_data <= w_ext;
        else             r_tmo     <= r_tmo + TW'(1);
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.stall      = (r_state != IDLE);
  assign bus.mem_req    = (r_state == BUS);
  assign bus.mem_we     = (r_state == BUS) && !r_load;
  assign bus.mem_addr   = (r_state == BUS) ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata  = (r_state == BUS) ? r_wdata : 32'h0;
  assign bus.mem_be     = (r_state == BUS) ? r_be : 4'b0000;
  assign bus.wb_valid   = (r_state == DONE) && r_load;
  assign bus.wb_rd      = r_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.fault      = r_fault || w_tmo;
  assign bus.fault_addr = r_addr;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage that directly consumes the ALU output: the ALU result arrives as the effective address and rs2 as store data. The unit issues a single-beat request to the data memory with a req/ack handshake, generates byte enables and lane-replicated store data, and sign- or zero-extends load data for writeback. It stalls the pipeline while a request is outstanding and reports faults for misalignment, illegal func3 and bus timeout.

## Interface
- TIMEOUT_CYCLES, 16: number of cycles mem_req may stay high without mem_ack before a timeout fault.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX stage presents an operation.
- req_ready  out  1  unit is idle and can accept an operation.
- opcode  in  7  LOAD 7'b0000011 or STORE 7'b0100011; any other value is ignored.
- func3  in  3  access size and signedness.
- addr  in  32  effective address, taken from the ALU result.
- wdata  in  32  store data (rs2).
- rd  in  5  load destination register.
- mem_req  out  1  bus request, held until acknowledged.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  load word, valid in the cycle mem_ack is high.
- wb_valid  out  1  one-cycle pulse carrying load writeback.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- stall  out  1  high whenever state != IDLE.
- fault  out  1  one-cycle fault pulse.
- fault_addr  out  32  address of the faulting access.

## Operation
- FSM states: IDLE, BUS, DONE.
- Reset values: IDLE; all outputs 0, except req_ready = 1.
- IDLE:
  - req_ready = 1.
  - When req_valid is high and opcode is LOAD or STORE, the unit latches opcode, func3, addr, wdata and rd.
  - If func3 is illegal, or the access is misaligned (see Configuration), it pulses fault with fault_addr = addr and stays in IDLE.
  - Otherwise it moves to BUS.
  - Any other opcode is ignored.
- Legal func3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- BUS:
  - mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata hold stable.
  - On mem_ack, go to DONE.
  - A timeout counter, cleared on entry, increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES: pulse fault with fault_addr, drop mem_req, go to IDLE, and produce no writeback.
  - If ack arrives in the same cycle as the timeout, ack wins.
- DONE: lasts one cycle. For a load, wb_valid = 1 with wb_rd and wb_data; stores produce no wb_valid. Then go to IDLE.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - The unit shifts mem_rdata right by 8*addr[1:0] (halfword: 16*addr[1]).
  - LB and LH sign-extend from bit 7 and bit 15; LBU and LHU zero-extend.
  - mem_rdata is captured in the ack cycle.
- mem_ack while mem_req is low is ignored.

## Timing
- Accept: edge N samples req_valid & req_ready.
- mem_req is high from cycle N+1. Ack in cycle N+k gives wb_valid in cycle N+k+1, and req_ready returns in cycle N+k+2.
- Minimum load/store occupancy is 3 cycles (ack in the first BUS cycle).
- A fault on accept pulses in cycle N+1, and req_ready stays high; back-to-back accepts are allowed.
- stall is a pure decode of state with no extra latency; EX holds its outputs while stall = 1.
- Reset asserted mid-BUS: mem_req drops immediately (asynchronous), no wb_valid or fault pulse, and the unit returns to IDLE.

## Configuration
- MISALIGN_TRAP_EN:
  - Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, faults on accept and issues no bus access.
  - Undefined: the offending low address bits are ignored (halfword uses addr[1] only; word uses lane 0), the access proceeds aligned down, and no fault is raised.
- Illegal func3 faults in both configurations.

## Test plan
- LW at addr 0x100, ack after 2 BUS cycles, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111, wb_valid one cycle with wb_data 0xDEADBEEF, stall high 4 cycles.
- LB at 0x103, LBU at 0x103 with rdata 0x80FFFFFF -> wb_data 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x102, wdata 0x0000ABCD -> mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD, no wb_valid.
- LW at 0x101 -> with MISALIGN_TRAP_EN: fault pulse, fault_addr 0x101, no mem_req; without it: mem_addr 0x100, mem_be 1111, normal writeback.
- No ack for TIMEOUT_CYCLES=16 -> fault in the 16th cycle without ack, mem_req low next cycle, no wb_valid; also ack exactly at cycle 16 -> normal completion, no fault.
- rst pulsed during BUS -> mem_req, stall and wb_valid go low immediately, req_ready=1; a following LW completes normally.
